// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control/execute stage: operation codes,
// func field codes, ALUOp encodings and the sequencer state type.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned ALUOP_W = 2;

  // Decoded operation codes
  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_LS  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SRS = 4'b0100;
  localparam logic [OP_W-1:0] OP_URS = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_ROR = 4'b1000;
  localparam logic [OP_W-1:0] OP_ROL = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1111;

  // func field codes used when ALUOp selects func decode
  localparam logic [FN_W-1:0] FN_ADD = 6'b000000;
  localparam logic [FN_W-1:0] FN_NOT = 6'b000001;
  localparam logic [FN_W-1:0] FN_SUB = 6'b000010;
  localparam logic [FN_W-1:0] FN_AND = 6'b000100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b000101;
  localparam logic [FN_W-1:0] FN_SLT = 6'b001010;
  localparam logic [FN_W-1:0] FN_URS = 6'b111001;
  localparam logic [FN_W-1:0] FN_SRS = 6'b111010;
  localparam logic [FN_W-1:0] FN_ROR = 6'b111011;
  localparam logic [FN_W-1:0] FN_LS  = 6'b111101;
  localparam logic [FN_W-1:0] FN_ROL = 6'b111110;

  // ALUOp encodings
  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNC = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Operations executed one bit per cycle by the sequencer
  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_LS)  || (op == OP_URS) || (op == OP_SRS) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// ALU control: maps (alu_op, func) to the 4-bit operation code and flags
// shift/rotate and undefined encodings. Illegal encodings report ADD.
module alu_func_decode
  import alu_pkg::*;
#(
  parameter int unsigned FUNC_W = 6
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNC_W-1:0]  func,
  output logic [OP_W-1:0]    operation_c,
  output logic               is_shift_c,
  output logic               illegal_c
);

  always_comb begin
    operation_c = OP_ADD;
    illegal_c   = 1'b0;
    case (alu_op)
      ALUOP_ADD: operation_c = OP_ADD;
      ALUOP_SUB: operation_c = OP_SUB;
      ALUOP_FUNC: begin
        case (func)
          FUNC_W'(FN_ADD): operation_c = OP_ADD;
          FUNC_W'(FN_SUB): operation_c = OP_SUB;
          FUNC_W'(FN_AND): operation_c = OP_AND;
          FUNC_W'(FN_OR):  operation_c = OP_OR;
          FUNC_W'(FN_NOT): operation_c = OP_NOT;
          FUNC_W'(FN_SLT): operation_c = OP_SLT;
          FUNC_W'(FN_LS):  operation_c = OP_LS;
          FUNC_W'(FN_URS): operation_c = OP_URS;
          FUNC_W'(FN_SRS): operation_c = OP_SRS;
          FUNC_W'(FN_ROR): operation_c = OP_ROR;
          FUNC_W'(FN_ROL): operation_c = OP_ROL;
          default:         illegal_c   = 1'b1;
        endcase
      end
      ALUOP_ILL: illegal_c = 1'b1;
      default:   illegal_c = 1'b1;
    endcase
  end

  assign is_shift_c = is_shift_op(operation_c) && !illegal_c;

endmodule

// File: rtl/alu_seq_exec.sv
// Handshaked ALU execute stage: single-cycle arithmetic/logic ops and
// iterative one-bit-per-cycle shifts/rotates, with a held DONE result.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned FUNC_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNC_W-1:0]  func,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [OP_W-1:0]    operation,
  output logic               zero,
  output logic               illegal
);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;

  logic [OP_W-1:0]    dec_op;
  logic               dec_shift;
  logic               dec_illegal;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               start_shift;
  logic [WIDTH-1:0]   exec_res;
  logic [WIDTH-1:0]   step_res;

  alu_func_decode #(
    .FUNC_W (FUNC_W)
  ) u_decode (
    .alu_op      (alu_op),
    .func        (func),
    .operation_c (dec_op),
    .is_shift_c  (dec_shift),
    .illegal_c   (dec_illegal)
  );

  assign shamt       = b[SHAMT_W-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = dec_shift && (shamt != '0);

  // Single-cycle result at acceptance; a zero-amount shift passes a through
  always_comb begin
    exec_res = '0;
    if (dec_illegal) begin
      exec_res = '0;
    end else if (dec_shift) begin
      exec_res = a;
    end else begin
      case (dec_op)
        OP_ADD:  exec_res = a + b;
        OP_SUB:  exec_res = a - b;
        OP_AND:  exec_res = a & b;
        OP_OR:   exec_res = a | b;
        OP_NOT:  exec_res = ~a;
        OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        default: exec_res = '0;
      endcase
    end
  end

  // One-bit step of the latched shift/rotate operation on the work register
  always_comb begin
    step_res = work;
    case (operation)
      OP_LS:   step_res = {work[WIDTH-2:0], 1'b0};
      OP_URS:  step_res = {1'b0, work[WIDTH-1:1]};
      OP_SRS:  step_res = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROR:  step_res = {work[0], work[WIDTH-1:1]};
      OP_ROL:  step_res = {work[WIDTH-2:0], work[WIDTH-1]};
      default: step_res = work;
    endcase
  end

  // Sequencer with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      operation <= OP_ADD;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready  <= 1'b0;
            operation <= dec_op;
            illegal   <= dec_illegal;
            if (start_shift) begin
              work  <= a;
              cnt   <= shamt;
              state <= SHIFT;
            end else begin
              result    <= exec_res;
              zero      <= (exec_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= step_res;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= step_res;
            zero      <= (step_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec (WIDTH=8): expected results from a
// behavioural model are queued at issue and compared when out_valid rises.
module tb_alu_seq_exec;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] func;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] operation;
  logic       zero;
  logic       illegal;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] op;
    logic       z;
    logic       ill;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  alu_seq_exec #(
    .WIDTH   (8),
    .SHAMT_W (3),
    .FUNC_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .operation (operation),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: whole-amount shifts, not bit-serial
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [7:0] av, input logic [7:0] bv);
    exp_t        e;
    logic [15:0] d;
    int unsigned k;
    logic        sh;
    k  = int'(bv[2:0]);
    sh = 1'b0;
    e  = '0;
    e.op  = 4'b0010;
    e.lat = 8'd1;
    if (op == 2'b00) e.res = av + bv;
    else if (op == 2'b01) begin e.op = 4'b0110; e.res = av - bv; end
    else if (op == 2'b11) e.ill = 1'b1;
    else begin
      case (fn)
        6'b000000: e.res = av + bv;
        6'b000010: begin e.op = 4'b0110; e.res = av - bv; end
        6'b000100: begin e.op = 4'b0000; e.res = av & bv; end
        6'b000101: begin e.op = 4'b0001; e.res = av | bv; end
        6'b000001: begin e.op = 4'b1111; e.res = ~av; end
        6'b001010: begin e.op = 4'b0111; e.res = ($signed(av) < $signed(bv)) ? 8'd1 : 8'd0; end
        6'b111101: begin e.op = 4'b0011; e.res = av << k; sh = 1'b1; end
        6'b111001: begin e.op = 4'b0101; e.res = av >> k; sh = 1'b1; end
        6'b111010: begin e.op = 4'b0100; e.res = 8'($signed(av) >>> k); sh = 1'b1; end
        6'b111011: begin e.op = 4'b1000; d = {av, av} >> k; e.res = d[7:0]; sh = 1'b1; end
        6'b111110: begin e.op = 4'b1001; d = {av, av} << k; e.res = d[15:8]; sh = 1'b1; end
        default:   e.ill = 1'b1;
      endcase
    end
    if (sh && k != 0) e.lat = 8'(k + 1);
    e.z = (e.res == 8'd0);
    return e;
  endfunction

  // Issue one request, wait for its result, hold it for 'hold' cycles, release
  task automatic run_txn(input logic [1:0] op, input logic [5:0] fn,
                         input logic [7:0] av, input logic [7:0] bv, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, fn, av, bv));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    alu_op    = op;
    func      = fn;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    // Keep a request pending with different operands; it must be ignored
    a      = ~av;
    b      = bv ^ 8'h5A;
    func   = fn ^ 6'h3F;
    alu_op = ~op;
    lat    = 1;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("result", 32'(result), 32'(e.res));
    check("operation", 32'(operation), 32'(e.op));
    check("zero", 32'(zero), 32'(e.z));
    check("illegal", 32'(illegal), 32'(e.ill));
    check("done_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'(e.res));
      check("hold_operation", 32'(operation), 32'(e.op));
      check("hold_flags", 32'({zero, illegal}), 32'({e.z, e.ill}));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  logic [5:0] fn_tab [11];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = 2'b00;
    func      = 6'd0;
    a         = 8'd0;
    b         = 8'd0;
    fn_tab = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b000001, 6'b001010,
               6'b111101, 6'b111001, 6'b111010, 6'b111011, 6'b111110};
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    check("rst_operation", 32'(operation), 32'h2);
    check("rst_flags", 32'({zero, illegal}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(2'b00, 6'b000000, 8'h7F, 8'h01, 0);
    run_txn(2'b10, 6'b001010, 8'hFE, 8'h01, 0);
    run_txn(2'b10, 6'b001010, 8'h01, 8'hFE, 0);
    run_txn(2'b10, 6'b111010, 8'h90, 8'h03, 0);
    run_txn(2'b10, 6'b111001, 8'h90, 8'h03, 0);
    run_txn(2'b10, 6'b111110, 8'h81, 8'h01, 0);
    run_txn(2'b10, 6'b111110, 8'h81, 8'h00, 0);
    run_txn(2'b10, 6'b111110, 8'h81, 8'h09, 0);
    run_txn(2'b10, 6'b010101, 8'h33, 8'h44, 3);
    run_txn(2'b11, 6'b000000, 8'h12, 8'h34, 1);

    // Abort an in-flight shift with an asynchronous reset
    run_txn(2'b01, 6'b000000, 8'h50, 8'h10, 0);
    alu_op   = 2'b10;
    func     = 6'b111101;
    a        = 8'h01;
    b        = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_operation", 32'(operation), 32'h2);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_valid", 32'(out_valid), 32'd0);
    run_txn(2'b10, 6'b111101, 8'h01, 8'h07, 0);

    for (int n = 0; n < 30; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 4) > 1 ? 2 : $urandom_range(0, 3));
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 10)];
      run_txn(op, fn, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Parametrised, handshaked ALU control-and-execute stage for the microprocessor datapath.
- Decodes ALUOp/func into the 4-bit operation code and executes the operation on WIDTH-bit operands.
- Executes shifts and rotates iteratively, one bit per cycle, by a variable amount.
- Flags undefined encodings instead of holding a stale operation.
- Sits between the register-read stage and writeback; uses valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4.
SHAMT_W, $clog2(WIDTH), shift-amount width taken from b.
FUNC_W, 6, func field width.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  request present.
in_ready  out  1  block can accept; high only in IDLE.
alu_op  in  2  00 = ADD, 01 = SUB, 10 = decode func, 11 = illegal.
func  in  FUNC_W  function field.
a  in  WIDTH  operand A (shifted/rotated operand).
b  in  WIDTH  operand B; low SHAMT_W bits are the shift amount.
out_valid  out  1  result held valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  registered result.
operation  out  4  registered decoded operation code.
zero  out  1  result == 0.
illegal  out  1  undefined alu_op/func for this result.

Behaviour:
- Operation codes:
  - ADD 0010, SUB 0110, AND 0000, OR 0001, NOT 1111, SLT 0111
  - LS 0011, URS 0101, SRS 0100, ROR 1000, ROL 1001
- func map (alu_op = 10):
  - 000000 ADD, 000010 SUB, 000100 AND, 000101 OR, 000001 NOT, 001010 SLT
  - 111101 LS, 111001 URS, 111010 SRS, 111011 ROR, 111110 ROL
  - Any other func, or alu_op = 11: illegal.
- Reset (async assert): state = IDLE, result = 0, operation = 0010, out_valid = 0, zero = 0, illegal = 0, shift counter = 0. Any in-flight shift is aborted and discarded.
- States and transitions:
  - IDLE: in_ready = 1. Accept when in_valid & in_ready.
  - IDLE, non-shift op or illegal accepted: the acceptance edge writes result/operation/illegal/zero; next state DONE. Latency 1.
  - IDLE, shift/rotate with amount k = b[SHAMT_W-1:0]:
    - k = 0: result = a, next state DONE.
    - k > 0: load work reg = a and cnt = k, next state SHIFT.
  - SHIFT: each edge performs a 1-bit step and cnt decrements. On the edge where cnt == 1, write result, go to DONE. Latency k+1 edges from acceptance.
  - DONE: out_valid = 1. result/operation/zero/illegal held stable while out_ready = 0. On out_valid & out_ready, go to IDLE and clear out_valid. No new acceptance in the same cycle.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH, two's complement.
  - AND/OR are bitwise; NOT = ~a (b ignored).
  - SLT: signed compare a < b; result = {WIDTH-1 zeros, lt}.
- Shift/rotate steps:
  - LS: shift left, zero fill.
  - URS: shift right, zero fill.
  - SRS: shift right, fill with MSB.
  - ROR: bit0 moves to MSB.
  - ROL: MSB moves to bit0.
  - Amount is b mod WIDTH (b >= WIDTH wraps).
- Illegal: result = 0, illegal = 1, zero = 1, operation = 0010. Completes in 1 cycle like a normal op.
- Inputs while in SHIFT/DONE are ignored (in_ready = 0). Operands are captured only at acceptance; later input changes have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - Operation code constants.
  - func code constants.
  - ALUOp encodings.
  - State enum (IDLE, SHIFT, DONE).
- One combinational sub-module alu_func_decode: (alu_op, func) -> operation, is_shift, illegal.
- Top level holds the FSM, operand/work registers, shift counter and the execute datapath.

Test Plan:
1. alu_op=00, a=0x7F, b=0x01 -> out_valid 1 edge after accept; result=0x80, operation=0010, zero=0, illegal=0.
2. alu_op=10, func=001010, a=0xFE, b=0x01 -> result=0x01 (signed -2<1); a=0x01, b=0xFE -> result=0x00, zero=1.
3. a=0x90, b=3 -> func=111010 (SRS) gives result=0xF2 and func=111001 (URS) gives 0x12, each with out_valid 4 edges after accept; in_ready=0 throughout.
4. func=111110 (ROL), a=0x81:
   - b=1 -> result=0x03 after 2 edges.
   - b=0 -> result=0x81 after 1 edge.
   - b=9 -> result=0x03 (amount wraps to 1).
5. alu_op=10, func=010101 -> illegal=1, result=0x00, zero=1. Then hold out_ready=0 for 3 cycles: outputs stable, a new in_valid is not accepted. out_ready=1 -> IDLE next edge.
6. Start LS with b=7; assert rst during the 3rd SHIFT cycle -> immediately out_valid=0, result=0x00, operation=0010, in_ready=1. The next request is processed normally.
